// File: rtl/dense.sv
// rtl/dense.sv - one fully-connected output neuron: bias + sum data[k]*kernel[k], binary32, one MAC per clock
module dense #(
    parameter int DEPTH      = 64,
    parameter int H          = 5,
    parameter int W          = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUMS       = DEPTH * H * W
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [DATA_WIDTH*NUMS-1:0] data_i,
    input  logic [DATA_WIDTH*NUMS-1:0] kernel_i,
    input  logic [DATA_WIDTH-1:0]      bias_i,
    output logic                       busy_o,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      result_o
);

    localparam int IW = $clog2(NUMS + 1);
    localparam logic [IW-1:0] LAST = IW'(NUMS - 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q;
    logic [IW-1:0]   index_r;
    logic [31:0]     acc_r;
    logic [31:0]     elem_d;
    logic [31:0]     elem_k;
    logic [31:0]     step_sum;

    // Round-to-nearest-even on a normalised 24-bit significand, then overflow/flush-to-zero.
    function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                            input logic [23:0] m, input logic g, input logic st);
        logic [24:0]        r;
        logic signed [9:0]  e1;
        logic [31:0]        res;
        r  = {1'b0, m} + {24'd0, g & (st | m[0])};
        e1 = r[24] ? e + 10'sd1 : e;
        if (e1 >= 10'sd255)
            res = {s, 8'hFF, 23'd0};
        else if (e1 <= 10'sd0)
            res = {s, 31'd0};
        else
            res = {s, e1[7:0], r[24] ? 23'd0 : r[22:0]};
        return res;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0]       prod;
        logic signed [9:0] e;
        logic [31:0]       res;
        s      = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
        b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
        a_nan  = (&a[30:23]) && (a[22:0] != 23'd0);
        b_nan  = (&b[30:23]) && (b[22:0] != 23'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = QNAN;
        else if (a_inf || b_inf)
            res = {s, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            res = {s, 31'd0};
        else if (prod[47])
            res = fp_pack(s, e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
        else
            res = fp_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
        return res;
    endfunction

    // Three extra bits (guard, round, sticky) are enough for correct RNE in both add and subtract.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [31:0]       hi, lo, res;
        logic [7:0]        d;
        logic [49:0]       shifted;
        logic [26:0]       hi27, lo27, diff, m27;
        logic [27:0]       sum28;
        logic [4:0]        lz;
        logic signed [9:0] e;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
        b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
        a_nan  = (&a[30:23]) && (a[22:0] != 23'd0);
        b_nan  = (&b[30:23]) && (b[22:0] != 23'd0);
        hi      = (a[30:0] >= b[30:0]) ? a : b;
        lo      = (a[30:0] >= b[30:0]) ? b : a;
        d       = hi[30:23] - lo[30:23];
        shifted = {1'b1, lo[22:0], 26'd0} >> d;
        hi27    = {1'b1, hi[22:0], 3'b000};
        lo27    = {shifted[49:24], shifted[23] | (|shifted[22:0]) | (d > 8'd49)};
        sum28   = {1'b0, hi27} + {1'b0, lo27};
        diff    = hi27 - lo27;
        lz      = 5'd0;
        for (int i = 0; i < 27; i++)
            if (diff[i]) lz = 5'(26 - i);
        if (sum28[27]) begin
            m27 = {sum28[27:2], sum28[1] | sum28[0]};
            e   = $signed({2'b00, hi[30:23]}) + 10'sd1;
        end else begin
            m27 = sum28[26:0];
            e   = $signed({2'b00, hi[30:23]});
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            res = QNAN;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (a_zero && b_zero)
            res = 32'd0;
        else if (a_zero)
            res = b;
        else if (b_zero)
            res = a;
        else if (hi[31] == lo[31])
            res = fp_pack(hi[31], e, m27[26:3], m27[2], |m27[1:0]);
        else if (diff == 27'd0)
            res = 32'd0;
        else begin
            m27 = diff << lz;
            e   = $signed({2'b00, hi[30:23]}) - $signed({5'b00000, lz});
            res = fp_pack(hi[31], e, m27[26:3], m27[2], |m27[1:0]);
        end
        return res;
    endfunction

    assign elem_d   = data_i[int'(index_r)*DATA_WIDTH +: DATA_WIDTH];
    assign elem_k   = kernel_i[int'(index_r)*DATA_WIDTH +: DATA_WIDTH];
    assign step_sum = fp_add(acc_r, fp_mul(elem_d, elem_k));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            index_r  <= '0;
            acc_r    <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_r   <= bias_i;
                        index_r <= '0;
                        busy_o  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_r   <= step_sum;
                    index_r <= index_r + 1'b1;
                    if (index_r == LAST) begin
                        result_o <= step_sum;
                        valid_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        index_r  <= '0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense.sv
// tb/tb_dense.sv - randomized and directed bench for dense against an exact-arithmetic float model
module tb_dense;

    localparam int NUMS = 4;
    typedef logic [319:0] wide_t;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [32*NUMS-1:0]   data;
    logic [32*NUMS-1:0]   kernel;
    logic [31:0]          bias;
    logic                 busy;
    logic                 valid;
    logic [31:0]          result;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    int          m_cnt = 0;
    bit          m_valid = 0;
    logic [31:0] m_result;
    logic [31:0] m_pending;

    dense #(.DEPTH(1), .H(2), .W(2), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_i    (rst),
        .start_i  (start),
        .data_i   (data),
        .kernel_i (kernel),
        .bias_i   (bias),
        .busy_o   (busy),
        .valid_o  (valid),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round the exact value (-1)^s * mag * 2^x to binary32 with flush-to-zero.
    function automatic logic [31:0] round_f32(input logic s, input wide_t mag, input int x);
        int    p, sh, e;
        wide_t m, rem, half;
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        e = x + p;
        if (p <= 23) m = mag << (23 - p);
        else begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag - (m << sh);
            half = wide_t'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m[24]) begin m = m >> 1; e = e + 1; end
        end
        if (e + 127 >= 255) return {s, 8'hFF, 23'd0};
        if (e + 127 <= 0) return {s, 31'd0};
        return {s, 8'(e + 127), m[22:0]};
    endfunction

    // 0 zero/subnormal, 1 normal, 2 inf, 3 nan
    function automatic int fclass(input logic [31:0] f);
        if (f[30:23] == 8'd0) return 0;
        if (f[30:23] != 8'hFF) return 1;
        return (f[22:0] == 23'd0) ? 2 : 3;
    endfunction

    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        int   ca, cb;
        logic s;
        ca = fclass(a); cb = fclass(b); s = a[31] ^ b[31];
        if (ca == 3 || cb == 3 || (ca == 2 && cb == 0) || (ca == 0 && cb == 2)) return QNAN;
        if (ca == 2 || cb == 2) return {s, 8'hFF, 23'd0};
        if (ca == 0 || cb == 0) return {s, 31'd0};
        return round_f32(s, wide_t'({1'b1, a[22:0]}) * wide_t'({1'b1, b[22:0]}),
                         int'(a[30:23]) + int'(b[30:23]) - 300);
    endfunction

    function automatic logic [31:0] add_ref(input logic [31:0] a, input logic [31:0] b);
        int    ca, cb, xa, xb, x;
        wide_t ma, mb;
        ca = fclass(a); cb = fclass(b);
        if (ca == 3 || cb == 3 || (ca == 2 && cb == 2 && a[31] != b[31])) return QNAN;
        if (ca == 2) return a;
        if (cb == 2) return b;
        if (ca == 0 && cb == 0) return 32'd0;
        if (ca == 0) return b;
        if (cb == 0) return a;
        xa = int'(a[30:23]) - 150;
        xb = int'(b[30:23]) - 150;
        x  = (xa < xb) ? xa : xb;
        ma = wide_t'({1'b1, a[22:0]}) << (xa - x);
        mb = wide_t'({1'b1, b[22:0]}) << (xb - x);
        if (a[31] == b[31]) return round_f32(a[31], ma + mb, x);
        if (ma == mb) return 32'd0;
        if (ma > mb) return round_f32(a[31], ma - mb, x);
        return round_f32(b[31], mb - ma, x);
    endfunction

    function automatic logic [31:0] job_ref(input logic [32*NUMS-1:0] d, input logic [32*NUMS-1:0] k,
                                            input logic [31:0] b);
        logic [31:0] acc;
        acc = b;
        for (int i = 0; i < NUMS; i++) acc = add_ref(acc, mul_ref(d[i*32 +: 32], k[i*32 +: 32]));
        return acc;
    endfunction

    function automatic logic [31:0] rand_f(input int mode);
        logic        s;
        logic [22:0] fr;
        int          r, lo_e, hi_e;
        s  = 1'($urandom_range(0, 1));
        fr = 23'($urandom);
        r  = $urandom_range(0, 99);
        if (mode == 1) begin
            if (r < 10) return {s, 31'd0};
            if (r < 20) return {s, 8'd0, fr | 23'd1};
            if (r < 25) return {s, 8'hFF, 23'd0};
            if (r < 28) return {s, 8'hFF, fr | 23'd1};
        end else if (r < 5) return {s, 31'd0};
        lo_e = (mode == 2) ? 1 : (mode == 3) ? 220 : 120;
        hi_e = (mode == 2) ? 30 : (mode == 3) ? 254 : 134;
        return {s, 8'($urandom_range(lo_e, hi_e)), fr};
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-level timing model: a start seen while idle completes NUMS edges later.
    always @(posedge clk) begin
        m_valid = 1'b0;
        if (rst) begin
            m_cnt    = 0;
            m_result = 32'd0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt     = NUMS;
                m_pending = job_ref(data, kernel, bias);
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_valid  = 1'b1;
                m_result = m_pending;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check32("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
            check32("valid", {31'd0, valid}, {31'd0, m_valid});
            check32("result", result, m_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string nm, input bit hold_start, input bit use_lit, input logic [31:0] lit);
        int cyc;
        bit seen;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < NUMS + 8) begin
            tick();
            cyc++;
            if (valid) seen = 1;
        end
        start = 1'b0;
        check32({nm, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(NUMS));
        if (use_lit) check32({nm, "_result"}, result, lit);
    endtask

    task automatic fill(input logic [31:0] d, input logic [31:0] k, input logic [31:0] b);
        for (int i = 0; i < NUMS; i++) begin
            data[i*32 +: 32]   = d;
            kernel[i*32 +: 32] = k;
        end
        bias = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  vcount, mode;
        rst = 1'b1; start = 1'b0; data = '0; kernel = '0; bias = '0;
        repeat (3) tick();
        chk_en = 1;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_valid", {31'd0, valid}, 32'd0);
        check32("reset_result", result, 32'd0);
        rst = 1'b0;
        tick();

        check32("pin_mul_ovf", mul_ref(32'h7F00_0000, 32'h4000_0000), 32'h7F80_0000);
        check32("pin_mul_ftz", mul_ref(32'h8080_0000, 32'h3F00_0000), 32'h8000_0000);
        check32("pin_add_cancel", add_ref(32'h3F80_0000, 32'hBF80_0000), 32'h0000_0000);
        check32("pin_add_tie_even", add_ref(32'h3F80_0001, 32'h3380_0000), 32'h3F80_0002);
        check32("pin_add_tie_keep", add_ref(32'h3F80_0000, 32'h3380_0000), 32'h3F80_0000);

        fill(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000);
        run_job("s1", 0, 1, 32'h4108_0000);
        tick();

        fill(32'h3F80_0000, 32'h0000_0000, 32'h4049_0FDB);
        run_job("s2", 0, 1, 32'h4049_0FDB);

        fill(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        run_job("s3", 0, 1, 32'hC080_0000);
        tick();

        fill(32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        data[31:0] = 32'h7F00_0000;
        kernel[31:0] = 32'h4000_0000;
        run_job("s4_inf", 0, 1, 32'h7F80_0000);
        data[63:32] = 32'h3F80_0000;
        kernel[63:32] = 32'hFF80_0000;
        run_job("s4_nan", 0, 1, 32'h7FC0_0000);
        tick();

        fill(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("s5_busy", {31'd0, busy}, 32'd0);
        check32("s5_result", result, 32'd0);
        vcount = 0;
        for (int i = 0; i < NUMS + 2; i++) begin
            tick();
            if (valid) vcount++;
        end
        check32("s5_no_valid", 32'(vcount), 32'd0);
        run_job("s5_after", 0, 1, 32'h4108_0000);
        tick();

        run_job("s6", 1, 1, 32'h4108_0000);
        tick();

        for (int j = 0; j < 150; j++) begin
            mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            for (int i = 0; i < NUMS; i++) begin
                data[i*32 +: 32]   = rand_f(mode);
                kernel[i*32 +: 32] = rand_f(mode);
            end
            bias = rand_f(mode);
            if ($urandom_range(0, 14) == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                repeat ($urandom_range(1, NUMS - 1)) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                run_job("rand", 1'($urandom_range(0, 1)), 0, 32'd0);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
